// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
// PS/2 keyboard front end. It synchronizes and deglitches the raw PS/2 lines,
// deframes 11-bit frames with an odd-parity check, and interprets the Set-2
// prefixes (E0 extended, F0 break, E1 pause). It emits one key event for each
// completed scan sequence.
// Optional build macro: PS2_TIMEOUT_EN. When it is defined, a receiver that
// stalls mid-frame for TIMEOUT_CYCLES clocks aborts the frame and pulses
// frame_err.
// Event timing: key_ready and frame_err assert two clocks after the edge on
// which the filtered falling edge of the stop bit is detected.
module ps2_scancode_decoder #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_ready,
  output logic       make,
  output logic       ext,
  output logic [7:0] key_code,
  output logic       frame_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_e;

  localparam logic [7:0] FILT_LAST = 8'(FILTER_LEN - 1);

  // Stop elaboration when the filter length or the timeout is out of range.
  if (FILTER_LEN < 2 || FILTER_LEN > 255 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("ps2_scancode_decoder: FILTER_LEN must be 2..255 and TIMEOUT_CYCLES >= 2");
  end

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;

  // Two-flop synchronizers. The idle bus level is high, so the flops reset to 1.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge; blocking assignments here would collapse
  // the chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Glitch filter on the PS/2 clock
  // ---------------------------------------------------------------------------
  logic       clk_filt_q;
  logic [7:0] filt_cnt_q;
  logic       fall_q;
  logic       filt_disagree;
  logic       filt_flip;

  assign filt_disagree = (clk_sync_q != clk_filt_q);
  assign filt_flip     = filt_disagree && (filt_cnt_q == FILT_LAST);

  // The filtered clock flips after FILTER_LEN consecutive disagreeing samples.
  // fall_q is a one-clock pulse that follows each filtered 1->0 transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_filt_q <= 1'b1;
      filt_cnt_q <= '0;
      fall_q     <= 1'b0;
    end else begin
      fall_q <= filt_flip & clk_filt_q;
      if (!filt_disagree) begin
        filt_cnt_q <= '0;
      end else if (filt_flip) begin
        clk_filt_q <= ~clk_filt_q;
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame receiver
  // ---------------------------------------------------------------------------
  rx_state_e  state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       parity_q, parity_d;
  logic       byte_valid_q, byte_valid_d;
  logic       bad_q, bad_d;
  logic [7:0] rx_byte_q;
  logic       timeout_hit;

`ifdef PS2_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] to_cnt_q;

  // Counts the idle clocks between filtered falling edges while a frame is open.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q <= '0;
    end else if (state_q == S_IDLE || fall_q || timeout_hit) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + 32'd1;
    end
  end

  assign timeout_hit = (state_q != S_IDLE) && !fall_q && (to_cnt_q == TO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state logic. Each filtered falling edge advances the receiver by one bit.
  // NOTE: every variable gets a default before the case statement, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    byte_valid_d = 1'b0;
    bad_d        = 1'b0;
    if (timeout_hit) begin
      state_d = S_IDLE;
      bad_d   = 1'b1;
    end else if (fall_q) begin
      unique case (state_q)
        S_IDLE: begin
          if (!data_sync_q) begin
            state_d   = S_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        S_DATA: begin
          shift_d = {data_sync_q, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = S_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        S_PARITY: begin
          parity_d = data_sync_q;
          state_d  = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (((^shift_q) ^ parity_q) && data_sync_q) begin
            byte_valid_d = 1'b1;
          end else begin
            bad_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Receiver state register. A good byte is held in rx_byte_q for the decoder.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      byte_valid_q <= 1'b0;
      bad_q        <= 1'b0;
      rx_byte_q    <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      byte_valid_q <= byte_valid_d;
      bad_q        <= bad_d;
      if (byte_valid_d) begin
        rx_byte_q <= shift_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scan-code sequence decoder
  // ---------------------------------------------------------------------------
  logic       ext_pend_q, brk_pend_q;
  logic [2:0] skip_q;
  logic       key_ready_q, make_q, ext_q, frame_err_q;
  logic [7:0] key_code_q;
  logic       is_response;

  // These bytes are device responses, not keys, unless a prefix is pending.
  assign is_response = rx_byte_q inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

  // Consumes one received byte per byte_valid pulse. A frame error discards
  // any partially collected sequence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      skip_q      <= '0;
      key_ready_q <= 1'b0;
      make_q      <= 1'b0;
      ext_q       <= 1'b0;
      key_code_q  <= '0;
      frame_err_q <= 1'b0;
    end else begin
      key_ready_q <= 1'b0;
      frame_err_q <= bad_q;
      if (bad_q) begin
        ext_pend_q <= 1'b0;
        brk_pend_q <= 1'b0;
        skip_q     <= '0;
      end else if (byte_valid_q) begin
        if (skip_q != 3'd0) begin
          skip_q <= skip_q - 3'd1;
        end else if (rx_byte_q == 8'hE1) begin
          skip_q <= 3'd7;  // drop the rest of the 8-byte Pause sequence
        end else if (rx_byte_q == 8'hE0) begin
          ext_pend_q <= 1'b1;
        end else if (rx_byte_q == 8'hF0) begin
          brk_pend_q <= 1'b1;
        end else if (is_response && !ext_pend_q && !brk_pend_q) begin
          // Device response; dropped.
        end else begin
          key_ready_q <= 1'b1;
          key_code_q  <= rx_byte_q;
          make_q      <= ~brk_pend_q;
          ext_q       <= ext_pend_q;
          ext_pend_q  <= 1'b0;
          brk_pend_q  <= 1'b0;
        end
      end
    end
  end

  assign key_ready = key_ready_q;
  assign make      = make_q;
  assign ext       = ext_q;
  assign key_code  = key_code_q;
  assign frame_err = frame_err_q;

endmodule
